regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, registered reads, two prioritised writes.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_ptr;
  logic                   r_busy;
  logic [N_RD*DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0]      r_mem [DEPTH];

  logic [ADDR_W-1:0]      w_ra [N_RD];
  logic [DATA_W-1:0]      w_rd_next [N_RD];
  logic                   w_we0;
  logic                   w_we1;

  // Writes to the hardwired zero entry are discarded
  assign w_we0 = we0 && !(ZR && (wa0 == '0));
  assign w_we1 = we1 && !(ZR && (wa1 == '0));

  // Next read value per lane, with optional same-cycle forwarding
  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      w_ra[k]      = rd_addr[k*ADDR_W +: ADDR_W];
      w_rd_next[k] = r_mem[w_ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (w_we0 && (wa0 == w_ra[k])) w_rd_next[k] = wd0;
      if (w_we1 && (wa1 == w_ra[k])) w_rd_next[k] = wd1;
`else
`endif
      if (ZR && (w_ra[k] == '0)) w_rd_next[k] = '0;
    end
  end

  // Storage: zero sweep while clearing, port writes (port 1 last) when ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else begin
        if (w_we0) r_mem[wa0] <= wd0;
        if (w_we1) r_mem[wa1] <= wd1;
      end
    end
  end

  // Clear/ready sequencer with registered busy and read lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_rd_data <= '0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_rd_data <= '0;
          r_ptr     <= r_ptr + PTR_ONE;
          if (&r_ptr) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          for (int k = 0; k < N_RD; k++)
            r_rd_data[k*DATA_W +: DATA_W] <= w_rd_next[k];
        end
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sequence, ports, priority, hazards.
// Second instance covers a narrow 3-read-port configuration.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        busy;

  logic        p_rst;
  logic        p_we0, p_we1;
  logic [2:0]  p_wa0, p_wa1;
  logic [15:0] p_wd0, p_wd1;
  logic [8:0]  p_rd_addr;
  logic [47:0] p_rd_data;
  logic        p_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  logic [31:0] exp_hz;

  always #5 clk = ~clk;

  regfile_mp u0 (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(3), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(p_rst),
    .we0(p_we0), .wa0(p_wa0), .wd0(p_wd0),
    .we1(p_we1), .wa1(p_wa1), .wd1(p_wd1),
    .rd_addr(p_rd_addr), .rd_data(p_rd_data), .busy(p_busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    tick();
  endtask

  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    tick();
    we0 = 0; we1 = 0;
  endtask

  // Count edges until busy drops; bounded
  task automatic count_clear(input string tag, input int exp_n,
                             input int wr_at);
    int c = 0;
    int bad = 0;
    while (busy && c < 40) begin
      if (c == wr_at) begin
        we0 = 1; wa0 = 5'd9; wd0 = 32'h1234;
      end else begin
        we0 = 0;
      end
      tick();
      c++;
      if (rd_data != 64'h0) bad++;
    end
    we0 = 0;
    check(tag, c, exp_n);
    check({tag, "_rd0"}, bad, 0);
  endtask

  initial begin
    rst = 1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    rd_addr = 0;
    p_rst = 1; p_we0 = 0; p_we1 = 0; p_wa0 = 0; p_wa1 = 0;
    p_wd0 = 0; p_wd1 = 0; p_rd_addr = 0;

    tick();
    tick();
    check("rst_busy", busy, 1);
    check("rst_rd", rd_data, 0);

    rst = 0;
    count_clear("clear_len", 32, -1);
    check("busy_low", busy, 0);

    wr(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    rd2(5'd5, 5'd5);
    check("basic_l0", rd_data[31:0], 32'hDEADBEEF);
    check("basic_l1", rd_data[63:32], 32'hDEADBEEF);

    wr(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    rd2(5'd7, 5'd5);
    check("prio_7", rd_data[31:0], 32'h22);
    check("keep_5", rd_data[63:32], 32'hDEADBEEF);

    wr(1, 5'd10, 32'h100, 1, 5'd11, 32'h200);
    rd2(5'd11, 5'd10);
    check("dual_11", rd_data[31:0], 32'h200);
    check("dual_10", rd_data[63:32], 32'h100);

    wr(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    rd2(5'd0, 5'd7);
    check("zero_reg", rd_data[31:0], 0);
    check("zero_l1", rd_data[63:32], 32'h22);

`ifdef REGFILE_BYPASS_EN
    exp_hz = 32'hA5A5A5A5;
`else
    exp_hz = 32'h0;
`endif
    rd_addr = {5'd3, 5'd3};
    wr(1, 5'd3, 32'hA5A5A5A5, 0, 0, 0);
    check("hazard_l0", rd_data[31:0], exp_hz);
    check("hazard_l1", rd_data[63:32], exp_hz);
    rd2(5'd3, 5'd0);
    check("hazard_next", rd_data[31:0], 32'hA5A5A5A5);

    rd_addr = {5'd0, 5'd12};
    wr(1, 5'd12, 32'h5, 1, 5'd12, 32'h6);
`ifdef REGFILE_BYPASS_EN
    check("byp_prio", rd_data[31:0], 32'h6);
`else
    check("byp_prio", rd_data[31:0], 32'h0);
`endif

    wr(1, 5'd9, 32'hCAFE, 1, 5'd31, 32'hBEEF);
    rd2(5'd9, 5'd31);
    check("pre_9", rd_data[31:0], 32'hCAFE);
    check("pre_31", rd_data[63:32], 32'hBEEF);

    rst = 1;
    wr(1, 5'd20, 32'h77, 0, 0, 0);
    check("rst2_busy", busy, 1);
    rst = 0;
    count_clear("clear_wr", 32, 3);
    begin
      int bad = 0;
      for (int a = 0; a < 32; a += 2) begin
        rd2(5'(a), 5'(a + 1));
        if (rd_data != 64'h0) bad++;
      end
      check("all_zero", bad, 0);
    end

    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    count_clear("clear_restart", 32, -1);

    tick();
    p_rst = 0;
    cnt = 0;
    while (p_busy && cnt < 20) begin
      tick();
      cnt++;
    end
    check("p_clear_len", cnt, 8);

    p_we0 = 1; p_wa0 = 3'd1; p_wd0 = 16'h1111;
    p_we1 = 1; p_wa1 = 3'd4; p_wd1 = 16'h4444;
    tick();
    p_we1 = 0; p_wa0 = 3'd6; p_wd0 = 16'h6666;
    tick();
    p_we0 = 0;
    p_rd_addr = {3'd6, 3'd4, 3'd1};
    tick();
    check("p_l0", p_rd_data[15:0], 16'h1111);
    check("p_l1", p_rd_data[31:16], 16'h4444);
    check("p_l2", p_rd_data[47:32], 16'h6666);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
